// File: rtl/ext_pkg.sv
// Shared definitions for the MIPS multiply extension: the ext_cont
// command encodings and the HI/LO sequencer state type.
package ext_pkg;

  localparam logic [3:0] EXT_NONE  = 4'b0000;
  localparam logic [3:0] EXT_MULTU = 4'b0010;
  localparam logic [3:0] EXT_MFLO  = 4'b0100;
  localparam logic [3:0] EXT_MFHI  = 4'b0101;
  localparam logic [3:0] EXT_JR    = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  // True for the two commands that read HI or LO.
  function automatic logic is_mf_code(input logic [3:0] code);
    return (code == EXT_MFLO) || (code == EXT_MFHI);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One step of the unsigned shift-add multiplier. The carry out of the
// add is kept as the top bit of the sum so it shifts into HI's MSB,
// and the sum's LSB shifts into LO's MSB.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  // Add the multiplicand when the current multiplier bit (LO[0]) is set.
  assign w_addend = i_lo[0] ? {1'b0, i_mcand} : '0;
  assign w_sum    = {1'b0, i_hi} + w_addend;

  // {hi, lo} <= {sum, lo[WIDTH-1:1]} : a 2*WIDTH-bit right shift.
  assign o_hi = w_sum[WIDTH:1];
  assign o_lo = {w_sum[0], i_lo[WIDTH-1:1]};

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO sequencer for the multu/mflo/mfhi extension. Runs a WIDTH-step
// iterative multiply and stalls only the instructions that depend on
// HI/LO (another multu or an mf read) while it is running.
module mul_hilo_ctrl
  import ext_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [3:0]       ext_cont,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mul_state_e       r_state;
  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_mul;
  logic             w_is_mf;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  assign w_is_mul = ex_valid && (ext_cont == EXT_MULTU);
  assign w_is_mf  = ex_valid && is_mf_code(ext_cont);

  // Only HI/LO consumers wait; jr and everything else flow past a multiply.
  assign stall = r_busy && (w_is_mul || w_is_mf);
  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .i_mcand (r_mcand),
    .o_hi    (w_step_hi),
    .o_lo    (w_step_lo)
  );

  // Sequencer: accept multu in IDLE, then perform one shift-add step per cycle.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mul) begin
            r_mcand <= rs_val;
            r_lo    <= rt_val;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Read port for mfhi/mflo; meaningful only when not stalled.
  // NOTE: default assignment first so no path leaves mf_data unassigned (no latch).
  always_comb begin
    mf_data = '0;
    if (w_is_mf) begin
      mf_data = (ext_cont == EXT_MFHI) ? r_hi : r_lo;
    end
  end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencer for the unsigned-multiply extension of the MIPS pipeline. Owns the HI/LO register pair and a 32-step iterative shift-add multiplier. Accepts `multu`, `mflo` and `mfhi` commands from the EX stage, encoded as `ext_cont`. Stalls the pipeline while HI/LO is being computed.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. Step count equals `WIDTH`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_valid`  in  1  an instruction is present in EX and is not being flushed.
- `ext_cont`  in  4  extension control: 0010 = multu, 0100 = mflo, 0101 = mfhi; any other value = no operation.
- `rs_val`  in  WIDTH  multiplicand.
- `rt_val`  in  WIDTH  multiplier.
- `stall`  out  1  freeze the IF, ID and EX stages this cycle (combinational).
- `busy`  out  1  a multiply is in progress (registered).
- `mf_data`  out  WIDTH  HI for mfhi, LO for mflo, 0 otherwise (combinational).
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.

## Operation
- Clocking: one clock, `clk`. `reset` is synchronous and active-high.
- FSM states: IDLE, RUN. A 5-bit step counter `cnt` (log2 WIDTH bits) and a `WIDTH`-bit multiplicand register `mcand` support the FSM.
- Command decode:
  - `is_mul` = `ex_valid` & (`ext_cont` == 0010).
  - `is_mf` = `ex_valid` & `ext_cont` ∈ {0100, 0101}.
- `stall` = `busy` & (`is_mul` | `is_mf`). Any other instruction, including jr, flows freely past a running multiply.
- IDLE with `is_mul`: load `mcand` ← `rs_val`, `lo` ← `rt_val`, `hi` ← 0, `cnt` ← 0. Go to RUN.
- RUN, each cycle:
  - `sum[WIDTH:0]` = {1'b0, `hi`} + (`lo[0]` ? {1'b0, `mcand`} : 0).
  - {`hi`, `lo`} ← {`sum`, `lo[WIDTH-1:1]`}.
  - `cnt` ← `cnt` + 1.
  - When `cnt` == WIDTH-1, that step is the last one; go to IDLE.
- Arithmetic: unsigned only. The carry out of each add is captured in `sum[WIDTH]` and shifted into `hi[WIDTH-1]`. After WIDTH steps, {`hi`, `lo`} holds the exact 2·WIDTH-bit product. No overflow is possible.
- `mf_data` reads `hi` or `lo` directly. It is valid only while `busy` = 0, because a stalled mf re-presents itself on the next cycle.
- A `multu` while RUN is stalled. It is accepted on the first cycle `busy` = 0.
- `reset` in any state, including mid-RUN: go to IDLE; `hi`, `lo`, `mcand` and `cnt` ← 0. The partial product is discarded.
- `ext_cont` values other than 0010, 0100 and 0101 never change state.

## Timing
- Reset values: `busy` 0, `stall` 0 (since `busy` = 0), `hi` 0, `lo` 0, `mf_data` 0.
- Issue: `multu` is sampled at edge E0, and `busy` = 1 from E0.
- Steps: edges E1 through E32 perform the 32 steps. `busy` = 0 after E32.
- Latency: 32 cycles of `busy` per multiply. HI and LO are final in the cycle following E32.
- An `mflo` or `mfhi` arriving in the cycle right after E0 sees `stall` = 1 for exactly 32 cycles. It completes in the first cycle with `busy` = 0, i.e. with zero extra bubble.
- Back-to-back `multu`: the second one stalls 32 cycles, is accepted at E32+1, and its result is ready 32 cycles later.
- `hi` and `lo` change every cycle during RUN. Their intermediate values are never architecturally visible, because all readers stall.
- `ex_valid` = 0 in a cycle suppresses that cycle's command and its stall.

## Structure
- Shared package `ext_pkg`:
  - `ext_cont` encodings: `EXT_NONE` = 0000, `EXT_MULTU` = 0010, `EXT_MFLO` = 0100, `EXT_MFHI` = 0101, `EXT_JR` = 1000. The extension decoder uses the same constants.
  - FSM state type {IDLE, RUN}.
- Sub-module `mul_step`: purely combinational. Inputs are `hi`, `lo` and `mcand`; outputs are next `hi` and next `lo` (the add and shift). `mul_hilo_ctrl` holds the FSM, counter, registers and stall logic.

## Test plan
- Simple product: `multu` with `rs`=3, `rt`=5, then idle for 32 cycles. Expect `busy` high for exactly 32 cycles, then `hi`=0 and `lo`=15.
- Maximum operands: `multu` 0xFFFFFFFF × 0xFFFFFFFF. Expect `hi`=0xFFFFFFFE and `lo`=0x00000001. This exercises the carry into `sum[32]`.
- Stall on read: `multu` 0x10000 × 0x10000, then `mfhi` on the next cycle. Expect `stall`=1 for 32 cycles, then `mf_data`=0x00000001 with `stall`=0. An `mflo` after that returns 0.
- Non-dependent instructions: during RUN, present `ext_cont`=1000 (jr) and 0000 with `ex_valid`=1. Expect `stall`=0 and the multiply still finishes on time with the correct result.
- Back-to-back: `multu` 7×6 immediately followed by `multu` 0x80000000×2. Expect the second to stall 32 cycles, then final `hi`=1, `lo`=0.
- Reset mid-operation: assert `reset` at step 10 of 0xFFFF×0xFFFF. Expect `busy`=0, `hi`=`lo`=0 on the next cycle. A new `multu` 2×2 then yields `lo`=4.
